// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter slice.
package div_pkg;

    localparam logic DIV_OP_UNSIGNED = 1'b0;
    localparam logic DIV_OP_SIGNED   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } arb_state_e;

    localparam int DIV_MAX_WIDTH = 64;

    // All-ones pattern of the given width, right-aligned in a 64-bit word.
    function automatic logic [DIV_MAX_WIDTH-1:0] div_all_ones(input int width);
        return {DIV_MAX_WIDTH{1'b1}} >> (DIV_MAX_WIDTH - width);
    endfunction

    // Most negative two's-complement value of the given width, right-aligned.
    function automatic logic [DIV_MAX_WIDTH-1:0] div_signed_min(input int width);
        return {{(DIV_MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Requester and divider bus of the divider arbiter.
// slave is the arbiter's view; master is the clients/divider view.
interface div_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       req_opcode;
    logic [NUM_REQ*WIDTH-1:0] req_dividend;
    logic [NUM_REQ*WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [WIDTH-1:0]         resp_quotient;
    logic [WIDTH-1:0]         resp_remainder;
    logic                     resp_err;
    logic                     div_valid_in;
    logic                     div_opcode;
    logic [WIDTH-1:0]         div_dividend;
    logic [WIDTH-1:0]         div_divisor;
    logic                     div_valid_out;
    logic [WIDTH-1:0]         div_quotient;
    logic [WIDTH-1:0]         div_remainder;

    modport slave (
        input  req_valid, req_opcode, req_dividend, req_divisor, resp_ready,
               div_valid_out, div_quotient, div_remainder,
        output req_ready, resp_valid, resp_quotient, resp_remainder, resp_err,
               div_valid_in, div_opcode, div_dividend, div_divisor
    );

    modport master (
        output req_valid, req_opcode, req_dividend, req_divisor, resp_ready,
               div_valid_out, div_quotient, div_remainder,
        input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_err,
               div_valid_in, div_opcode, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant_oh,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);
    localparam int IDXW = $clog2(NUM_REQ);

    logic [IDXW-1:0] pos;

    // Scan from rr_ptr upward, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = IDXW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any && req[pos]) begin
                any           = 1'b1;
                grant_idx     = pos;
                grant_oh[pos] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between NUM_REQ requesters, one op at a time.
// Divide-by-zero and signed overflow are answered locally; a hung divider is
// aborted after TIMEOUT cycles and its possible late answer drained.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | pick a requester, capture operands, bypass trivial cases
// ISSUE    | single-cycle div_valid_in pulse, clear timeout counter
// WAIT     | wait for div_valid_out or timeout
// RESP     | hold response to owner until resp_ready
// DRAIN    | swallow one late div_valid_out after a timeout (bounded)
module div_arbiter
    import div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input logic          clock,
    input logic          reset,
    div_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(div_all_ones(WIDTH));
    localparam logic [WIDTH-1:0] SMIN     = WIDTH'(div_signed_min(WIDTH));

    arb_state_e       state_q, state_d;
    logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]  owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             drain_q, drain_d;
    logic             opcode_q, opcode_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IDXW-1:0]    grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] owner_oh;
    logic [WIDTH-1:0]   dvd_arr [NUM_REQ];
    logic [WIDTH-1:0]   dvs_arr [NUM_REQ];
    logic [WIDTH-1:0]   sel_dividend, sel_divisor;
    logic               sel_opcode;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign dvd_arr[g] = bus.req_dividend[g*WIDTH +: WIDTH];
        assign dvs_arr[g] = bus.req_divisor[g*WIDTH +: WIDTH];
    end

    assign sel_dividend = dvd_arr[grant_idx];
    assign sel_divisor  = dvs_arr[grant_idx];
    assign sel_opcode   = bus.req_opcode[grant_idx];

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // One-hot decode of the current owner for resp_valid.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        opcode_d   = opcode_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    owner_d    = grant_idx;
                    opcode_d   = sel_opcode;
                    dividend_d = sel_dividend;
                    divisor_d  = sel_divisor;
                    err_d      = 1'b0;
                    if (sel_divisor == '0) begin
                        quot_d  = ALL_ONES;
                        rem_d   = sel_dividend;
                        state_d = ST_RESP;
                    end else if (sel_opcode == DIV_OP_SIGNED && sel_dividend == SMIN &&
                                 sel_divisor == ALL_ONES) begin
                        quot_d  = SMIN;
                        rem_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.div_valid_out) begin
                    quot_d  = bus.div_quotient;
                    rem_d   = bus.div_remainder;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready[owner_q]) begin
                    rr_ptr_d = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    cnt_d    = '0;
                    state_d  = drain_q ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.div_valid_out || cnt_q == CNT_LAST) begin
                    drain_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            opcode_q   <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            opcode_q   <= opcode_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready      = (state_q == ST_IDLE) ? grant_oh : '0;
    assign bus.resp_valid     = (state_q == ST_RESP) ? owner_oh : '0;
    assign bus.resp_quotient  = quot_q;
    assign bus.resp_remainder = rem_q;
    assign bus.resp_err       = err_q;
    assign bus.div_valid_in   = (state_q == ST_ISSUE);
    assign bus.div_opcode     = opcode_q;
    assign bus.div_dividend   = dividend_q;
    assign bus.div_divisor    = divisor_q;
endmodule
